// File: rtl/parser_pkg.sv
// Shared constants and types for the ITCH byte-stream parser and its helpers.
package parser_pkg;

  localparam logic [7:0] MSG_ADD  = 8'h41;
  localparam logic [7:0] MSG_EXEC = 8'h45;
  localparam logic [7:0] MSG_DEL  = 8'h44;

  localparam logic [4:0] LEN_ADD  = 5'd17;
  localparam logic [4:0] LEN_EXEC = 5'd13;
  localparam logic [4:0] LEN_DEL  = 5'd9;

  typedef enum logic {IDLE, BODY} state_t;

  typedef struct packed {
    logic [7:0]  mtype;
    logic [63:0] order_id;
    logic [31:0] price;
    logic [31:0] volume;
  } msg_t;

  // Total message length including the type byte; 0 marks an unknown type.
  function automatic logic [4:0] msg_len(input logic [7:0] t);
    case (t)
      MSG_ADD:  msg_len = LEN_ADD;
      MSG_EXEC: msg_len = LEN_EXEC;
      MSG_DEL:  msg_len = LEN_DEL;
      default:  msg_len = 5'd0;
    endcase
  endfunction

endpackage

// File: rtl/gap_timer.sv
// Idle-cycle counter with a loadable limit; o_tc fires combinationally on the
// enabled cycle that completes i_limit counted cycles, and the count restarts.
module gap_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_clr,
  input  logic         i_en,
  input  logic [W-1:0] i_limit,
  output logic         o_tc
);

  logic [W-1:0] r_cnt;
  logic [W-1:0] w_last;

  assign w_last = i_limit - {{(W-1){1'b0}}, 1'b1};
  assign o_tc   = i_en && !i_clr && (r_cnt == w_last);

  always_ff @(posedge clk) begin
    if (!rst_n)            r_cnt <= '0;
    else if (i_clr || o_tc) r_cnt <= '0;
    else if (i_en)         r_cnt <= r_cnt + {{(W-1){1'b0}}, 1'b1};
  end

endmodule

// File: rtl/itch_msg_parser.sv
// Frames fixed-length big-endian ITCH order messages from a byte stream and
// presents each complete message on a valid/ready output with error stats.
module itch_msg_parser
  import parser_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       in_byte,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [7:0]       out_type,
  output logic [63:0]      out_order_id,
  output logic [31:0]      out_price,
  output logic [31:0]      out_volume,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             err_unknown,
  output logic             err_timeout,
  output logic [CNT_W-1:0] msg_count,
  output logic [CNT_W-1:0] err_count
);

  state_t             r_state, w_state_nx;
  logic [4:0]         r_idx, r_len;
  logic [63:0]        r_id,  w_id_nx;
  logic [31:0]        r_price, w_price_nx;
  logic [31:0]        r_vol, w_vol_nx;
  msg_t               r_out;
  logic               r_out_valid, r_err_unk, r_err_to;
  logic [CNT_W-1:0]   r_msg_cnt, r_err_cnt;

  logic w_acc, w_known, w_type_acc, w_unk, w_body_acc, w_last, w_to;
  logic w_tmr_clr, w_tmr_en;

  assign in_ready   = !r_out_valid || out_ready;
  assign w_acc      = in_valid && in_ready;
  assign w_known    = (msg_len(in_byte) != 5'd0);
  assign w_type_acc = (r_state == IDLE) && w_acc && w_known;
  assign w_unk      = (r_state == IDLE) && w_acc && !w_known;
  assign w_body_acc = (r_state == BODY) && w_acc;
  assign w_last     = w_body_acc && (r_idx == r_len - 5'd1);

  // Only stalls of the upstream count; output backpressure freezes the timer.
  assign w_tmr_clr  = (r_state == IDLE) || w_acc;
  assign w_tmr_en   = (r_state == BODY) && in_ready && !w_acc;

  gap_timer #(.W(16)) u_gap_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clr   (w_tmr_clr),
    .i_en    (w_tmr_en),
    .i_limit (16'(TIMEOUT_CYCLES)),
    .o_tc    (w_to)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      IDLE:    if (w_type_acc)      w_state_nx = BODY;
      BODY:    if (w_last || w_to)  w_state_nx = IDLE;
      default:                      w_state_nx = IDLE;
    endcase
  end

  // Byte index picks the field: 1-8 id, 9-12 price (A) or volume (E), 13-16 volume (A).
  always_comb begin
    w_id_nx    = r_id;
    w_price_nx = r_price;
    w_vol_nx   = r_vol;
    if (w_body_acc) begin
      if (r_idx <= 5'd8)                 w_id_nx    = {r_id[55:0], in_byte};
      else if (r_idx <= 5'd12 && r_out.mtype == MSG_ADD)
                                         w_price_nx = {r_price[23:0], in_byte};
      else                               w_vol_nx   = {r_vol[23:0], in_byte};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_idx       <= '0;
      r_len       <= '0;
      r_id        <= '0;
      r_price     <= '0;
      r_vol       <= '0;
      r_out       <= '0;
      r_out_valid <= 1'b0;
      r_err_unk   <= 1'b0;
      r_err_to    <= 1'b0;
      r_msg_cnt   <= '0;
      r_err_cnt   <= '0;
    end else begin
      r_err_unk <= w_unk;
      r_err_to  <= w_to;

      if (w_type_acc) begin
        r_out.mtype <= in_byte;
        r_len       <= msg_len(in_byte);
        r_idx       <= 5'd1;
        r_id        <= '0;
        r_price     <= '0;
        r_vol       <= '0;
      end else if (w_body_acc) begin
        r_idx   <= r_idx + 5'd1;
        r_id    <= w_id_nx;
        r_price <= w_price_nx;
        r_vol   <= w_vol_nx;
      end

      // A completing message wins over the handshake clear for back-to-back output.
      if (w_last) begin
        r_out.order_id <= w_id_nx;
        r_out.price    <= w_price_nx;
        r_out.volume   <= w_vol_nx;
        r_out_valid    <= 1'b1;
        r_msg_cnt      <= r_msg_cnt + 1'b1;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end

      if (w_unk || w_to) r_err_cnt <= r_err_cnt + 1'b1;
    end
  end

  assign out_type     = r_out.mtype;
  assign out_order_id = r_out.order_id;
  assign out_price    = r_out.price;
  assign out_volume   = r_out.volume;
  assign out_valid    = r_out_valid;
  assign err_unknown  = r_err_unk;
  assign err_timeout  = r_err_to;
  assign msg_count    = r_msg_cnt;
  assign err_count    = r_err_cnt;

endmodule

// File: tb/tb_itch_msg_parser.sv
// Randomized scoreboard bench: messages are encoded from field values, the
// expected decode is queued at issue time and a monitor checks DUT output.
module tb_itch_msg_parser;

  localparam int TO    = 8;
  localparam int CNT_W = 4;

  typedef struct packed {
    logic [7:0]  t;
    logic [63:0] id;
    logic [31:0] p;
    logic [31:0] v;
  } exp_t;

  logic             clk = 0;
  logic             rst_n = 0;
  logic [7:0]       in_byte = 0;
  logic             in_valid = 0;
  logic             in_ready;
  logic [7:0]       out_type;
  logic [63:0]      out_order_id;
  logic [31:0]      out_price, out_volume;
  logic             out_valid;
  logic             out_ready = 1;
  logic             err_unknown, err_timeout;
  logic [CNT_W-1:0] msg_count, err_count;

  itch_msg_parser #(.TIMEOUT_CYCLES(TO), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_byte(in_byte), .in_valid(in_valid),
    .in_ready(in_ready), .out_type(out_type), .out_order_id(out_order_id),
    .out_price(out_price), .out_volume(out_volume), .out_valid(out_valid),
    .out_ready(out_ready), .err_unknown(err_unknown), .err_timeout(err_timeout),
    .msg_count(msg_count), .err_count(err_count)
  );

  always #5 clk = ~clk;

  int   n_chk = 0, n_pass = 0;
  int   exp_msg = 0, exp_err = 0;
  int   mode = 1;          // 0 random out_ready, 1 always ready, 2 stalled
  exp_t exp_q[$];
  int   err_q[$];          // 0 unknown, 1 timeout

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic flag(input string name);
    n_chk++;
    $display("FAIL %s", name);
  endtask

  initial forever begin
    @(posedge clk); #1;
    case (mode)
      0:       out_ready = ($urandom_range(0, 3) != 0);
      1:       out_ready = 1'b1;
      default: out_ready = 1'b0;
    endcase
  end

  // Monitor: handshakes pop the message queue, error pulses pop the error queue.
  initial begin
    logic  hv;
    exp_t  saved;
    exp_t  e;
    int    k;
    hv = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) hv = 0;
      else begin
        chk("in_ready_rule", 160'(in_ready), 160'(!out_valid || out_ready));
        if (hv) chk("hold_stable", {out_valid, out_type, out_order_id, out_price, out_volume},
                    {1'b1, saved});
        hv    = out_valid && !out_ready;
        saved = {out_type, out_order_id, out_price, out_volume};
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) flag("unexpected_msg");
          else begin
            e = exp_q.pop_front();
            chk("msg_type",  160'(out_type),     160'(e.t));
            chk("msg_id",    160'(out_order_id), 160'(e.id));
            chk("msg_price", 160'(out_price),    160'(e.p));
            chk("msg_vol",   160'(out_volume),   160'(e.v));
          end
        end
        if (err_unknown || err_timeout) begin
          if (err_q.size() == 0) flag("unexpected_err");
          else begin
            k = err_q.pop_front();
            chk("err_kind", {err_unknown, err_timeout}, (k == 0) ? 160'd2 : 160'd1);
          end
        end
      end
    end
  end

  task automatic idle(input int n);
    in_valid = 0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    bit acc;
    n = 0; acc = 0;
    in_byte = b; in_valid = 1;
    while (!acc) begin
      @(negedge clk); acc = in_ready;
      @(posedge clk); #1;
      n++;
      if (!acc && n > 300) begin flag("accept_bound"); break; end
    end
    in_valid = 0;
  endtask

  // trunc < 0: full message; else type byte plus trunc body bytes then a timeout gap.
  task automatic send_msg(input logic [7:0] t, input logic [63:0] id, input logic [31:0] p,
                          input logic [31:0] v, input int gmax, input int trunc);
    logic [7:0] bq[$];
    exp_t e;
    int   n;
    bq.push_back(t);
    for (int i = 7; i >= 0; i--) bq.push_back(id[8*i +: 8]);
    if (t == 8'h41) for (int i = 3; i >= 0; i--) bq.push_back(p[8*i +: 8]);
    if (t != 8'h44) for (int i = 3; i >= 0; i--) bq.push_back(v[8*i +: 8]);
    e.t = t; e.id = id;
    e.p = (t == 8'h41) ? p : 32'd0;
    e.v = (t == 8'h44) ? 32'd0 : v;
    n = (trunc < 0) ? bq.size() : trunc + 1;
    if (trunc < 0) begin exp_q.push_back(e); exp_msg++; end
    else begin err_q.push_back(1); exp_err++; end
    for (int i = 0; i < n; i++) begin
      idle($urandom_range(0, gmax));
      send_byte(bq[i]);
    end
    if (trunc >= 0) idle(TO);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || err_q.size() != 0) && n < 500) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 500) flag("drain_bound");
    idle(2);
  endtask

  task automatic chk_counts(input string tag);
    chk({tag, "_msg_count"}, 160'(msg_count), 160'(CNT_W'(exp_msg)));
    chk({tag, "_err_count"}, 160'(err_count), 160'(CNT_W'(exp_err)));
  endtask

  function automatic logic [63:0] r64();
    return {$urandom, $urandom};
  endfunction

  function automatic logic [7:0] pick_type();
    int r;
    r = $urandom_range(0, 2);
    return (r == 0) ? 8'h41 : (r == 1) ? 8'h45 : 8'h44;
  endfunction

  initial begin
    logic [7:0] t, b;
    int len, r;

    // Reset state
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    @(negedge clk);
    chk("rst_fields", {out_type, out_order_id, out_price, out_volume}, 160'd0);
    chk("rst_flags", {out_valid, err_unknown, err_timeout, msg_count, err_count, in_ready},
        160'd1);
    @(posedge clk); #1;

    // Add message with fixed fields; one-cycle output right after the last byte
    send_msg(8'h41, 64'd1, 32'd10000, 32'd100, 0, -1);
    @(negedge clk); chk("a_latency_valid", 160'(out_valid), 160'd1);
    @(negedge clk); chk("a_single_cycle", 160'(out_valid), 160'd0);
    drain(); chk_counts("a");

    // Delete held under backpressure longer than the timeout, then Execute
    mode = 2;
    send_msg(8'h44, r64(), $urandom, $urandom, 0, -1);
    in_byte = 8'h45; in_valid = 1;
    repeat (20) begin @(posedge clk); #1; end
    @(negedge clk);
    chk("bp_in_ready", 160'(in_ready), 160'd0);
    chk("bp_held_type", {out_valid, out_type}, 160'h144);
    @(posedge clk); #1;
    mode = 1;
    send_msg(8'h45, r64(), $urandom, $urandom, 0, -1);
    drain(); chk_counts("de");

    // Unknown byte resyncs into a following Delete
    err_q.push_back(0); exp_err++;
    send_byte(8'h5A);
    send_msg(8'h44, r64(), 32'd0, 32'd0, 0, -1);
    drain(); chk_counts("unk");

    // Timeout: Add type plus 3 bytes, then idle; pulse follows the 8th idle cycle
    err_q.push_back(1); exp_err++;
    send_byte(8'h41); send_byte(8'h00); send_byte(8'h11); send_byte(8'h22);
    for (int k = 1; k <= TO + 1; k++) begin
      @(negedge clk);
      chk("to_pulse_timing", 160'(err_timeout), 160'(k == TO + 1));
    end
    @(posedge clk); #1;
    send_msg(8'h44, r64(), 32'd0, 32'd0, 0, -1);
    drain(); chk_counts("to");

    // Reset midway through an Add: silent discard, then a clean Add
    send_byte(8'h41);
    for (int i = 0; i < 5; i++) send_byte(8'($urandom));
    rst_n = 0;
    @(posedge clk); #1;
    rst_n = 1;
    @(negedge clk);
    chk("mid_rst_fields", {out_type, out_order_id, out_price, out_volume}, 160'd0);
    chk("mid_rst_flags", {out_valid, err_unknown, err_timeout, msg_count, err_count}, 160'd0);
    exp_msg = 0; exp_err = 0;
    @(posedge clk); #1;
    send_msg(8'h41, r64(), $urandom, $urandom, 0, -1);
    drain(); chk_counts("rst");

    // Random traffic with random downstream backpressure; counters wrap at CNT_W
    mode = 0;
    for (int i = 0; i < 70; i++) begin
      r = $urandom_range(0, 9);
      if (r == 0) begin
        do b = 8'($urandom); while (b == 8'h41 || b == 8'h44 || b == 8'h45);
        err_q.push_back(0); exp_err++;
        idle($urandom_range(0, 3));
        send_byte(b);
      end else begin
        t   = pick_type();
        len = (t == 8'h41) ? 17 : (t == 8'h45) ? 13 : 9;
        send_msg(t, r64(), $urandom, $urandom, 3,
                 (r == 1) ? $urandom_range(0, len - 2) : -1);
      end
    end
    drain(); chk_counts("rand");
    chk("queues_empty", 160'(exp_q.size() + err_q.size()), 160'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
